// File: rtl/button_evt_pkg.sv
// ============================================================================
//  Package : button_evt_pkg
//  Shared FSM encoding, direction codes and default gap for the button event
//  arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package button_evt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } evt_state_e;

    localparam logic DIR_DN = 1'b0;
    localparam logic DIR_UP = 1'b1;

    localparam int DEFAULT_GAP_CYCLES = 1000;

endpackage

`default_nettype wire

// File: rtl/button_event_arbiter_if.sv
// ============================================================================
//  Interface : button_event_arbiter_if
//  Valid/ready event stream carrying a channel index and press/release flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface button_event_arbiter_if #(
    parameter int IDW = 2
);
    logic           out_valid;
    logic           out_ready;
    logic [IDW-1:0] out_id;
    logic           out_dir;

    modport master (
        output out_valid,
        output out_id,
        output out_dir,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_id,
        input  out_dir,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Combinational round-robin selector: first set request at or above ptr,
//  wrapping from N-1 to 0.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  wire logic [N-1:0]   req,
    input  wire logic [IDW-1:0] ptr,
    output logic      [IDW-1:0] gnt_idx,
    output logic                gnt_any
);

    int w_idx;

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[IDW'(w_idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_event_arbiter.sv
// ============================================================================
//  Module  : button_event_arbiter
//  Latches press/release pulses from N debouncers and serialises them onto one
//  valid/ready stream, round-robin, with an idle gap after each transfer.
//  Optional overflow flags: define BUTTON_EVT_DROP_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module button_event_arbiter
    import button_evt_pkg::*;
#(
    parameter int N          = 4,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  wire logic                 CLK,
    input  wire logic                 RST_N,
    input  wire logic [N-1:0]         evt_dn,
    input  wire logic [N-1:0]         evt_up,
    button_event_arbiter_if.master    out_if,
    output logic      [2*N-1:0]       pending,
    output logic                      busy,
    output logic      [N-1:0]         drop,
    input  wire logic                 drop_clr
);

    localparam int                  IDW        = $clog2(N);
    localparam int                  c_cnt_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0]  c_gap_load = c_cnt_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDW-1:0]      c_last_idx = IDW'(N - 1);

    evt_state_e          state_q;
    logic                out_valid_q;
    logic                out_dir_q;
    logic [IDW-1:0]      out_id_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [c_cnt_w-1:0]  gap_cnt_q;

    logic [N-1:0]        pend_dn_q;
    logic [N-1:0]        pend_up_q;
    logic [N-1:0]        pend_dn_d;
    logic [N-1:0]        pend_up_d;

    logic [N-1:0]        w_req;
    logic [N-1:0]        w_clr_dn;
    logic [N-1:0]        w_clr_up;
    logic [IDW-1:0]      w_gnt_idx;
    logic                w_gnt_any;
    logic                w_grant;

    assign w_req = pend_dn_q | pend_up_q;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req     (w_req),
        .ptr     (rr_ptr_q),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign w_grant = (state_q == IDLE) && w_gnt_any;

    // Press is served before release within the granted channel.
    always_comb begin
        w_clr_dn = '0;
        w_clr_up = '0;
        if (w_grant) begin
            if (pend_dn_q[w_gnt_idx]) begin
                w_clr_dn[w_gnt_idx] = 1'b1;
            end else begin
                w_clr_up[w_gnt_idx] = 1'b1;
            end
        end
    end

    // A fresh pulse on a bit being granted re-arms it as a new event.
    assign pend_dn_d = (pend_dn_q & ~w_clr_dn) | evt_dn;
    assign pend_up_d = (pend_up_q & ~w_clr_up) | evt_up;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_dn_q <= '0;
            pend_up_q <= '0;
        end else begin
            pend_dn_q <= pend_dn_d;
            pend_up_q <= pend_up_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_dir_q   <= DIR_DN;
            rr_ptr_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_gnt_any) begin
                        out_id_q    <= w_gnt_idx;
                        out_dir_q   <= pend_dn_q[w_gnt_idx] ? DIR_DN : DIR_UP;
                        rr_ptr_q    <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                        end else begin
                            gap_cnt_q <= c_gap_load;
                            state_q   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_id    = out_id_q;
    assign out_if.out_dir   = out_dir_q;
    assign pending          = {pend_up_q, pend_dn_q};
    assign busy             = (state_q != IDLE);

`ifdef BUTTON_EVT_DROP_EN
    logic [N-1:0] drop_q;
    logic [N-1:0] drop_d;

    // A new overflow outranks a simultaneous clear.
    assign drop_d = (drop_clr ? '0 : drop_q)
                  | (evt_dn & pend_dn_q)
                  | (evt_up & pend_up_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop = drop_q;
`else
    logic w_unused_drop_clr;

    assign w_unused_drop_clr = drop_clr;
    assign drop              = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
// ============================================================================
//  Module  : tb_button_event_arbiter
//  Bench for button_event_arbiter: two instances (gap 0 and gap 10) share one
//  stimulus stream and are checked every cycle against an event-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

`ifdef BUTTON_EVT_DROP_EN
    localparam logic [N-1:0] c_drop_exp = 4'b0001;
`else
    localparam logic [N-1:0] c_drop_exp = 4'b0000;
`endif

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   evt_dn = '0;
    logic [N-1:0]   evt_up = '0;
    logic           drop_clr = 1'b0;
    logic           ready = 1'b0;

    logic [2*N-1:0] pend0, pend1;
    logic           busy0, busy1;
    logic [N-1:0]   drop0, drop1;

    button_event_arbiter_if #(.IDW(IDW)) bus0 ();
    button_event_arbiter_if #(.IDW(IDW)) bus1 ();

    assign bus0.out_ready = ready;
    assign bus1.out_ready = ready;

    button_event_arbiter #(.N(N), .GAP_CYCLES(0)) u_dut0 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .evt_dn   (evt_dn),
        .evt_up   (evt_up),
        .out_if   (bus0.master),
        .pending  (pend0),
        .busy     (busy0),
        .drop     (drop0),
        .drop_clr (drop_clr)
    );

    button_event_arbiter #(.N(N), .GAP_CYCLES(10)) u_dut1 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .evt_dn   (evt_dn),
        .evt_up   (evt_up),
        .out_if   (bus1.master),
        .pending  (pend1),
        .busy     (busy1),
        .drop     (drop1),
        .drop_clr (drop_clr)
    );

    initial forever #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- event-level model ----------------
    logic [N-1:0] m_pdn[2], m_pup[2], m_drop[2];
    logic         m_valid[2], m_dir[2];
    int           m_id[2], m_ptr[2], m_hold[2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 10;
    endfunction

    always @(posedge CLK or negedge RST_N) begin : p_model
        logic [N-1:0] odn, oup, cdn, cup;
        int c;
        for (int k = 0; k < 2; k++) begin
            if (!RST_N) begin
                m_pdn[k] = '0; m_pup[k] = '0; m_drop[k] = '0;
                m_valid[k] = 1'b0; m_dir[k] = 1'b0;
                m_id[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
            end else begin
                odn = m_pdn[k]; oup = m_pup[k]; cdn = '0; cup = '0;
                if (m_valid[k]) begin
                    if (ready) begin
                        m_valid[k] = 1'b0;
                        m_hold[k]  = gap_of(k);
                    end
                end else if (m_hold[k] > 0) begin
                    m_hold[k] = m_hold[k] - 1;
                end else begin
                    for (int j = 0; j < N; j++) begin
                        c = (m_ptr[k] + j) % N;
                        if (!m_valid[k] && (odn[c] || oup[c])) begin
                            if (odn[c]) begin cdn[c] = 1'b1; m_dir[k] = 1'b0; end
                            else        begin cup[c] = 1'b1; m_dir[k] = 1'b1; end
                            m_id[k]    = c;
                            m_valid[k] = 1'b1;
                            m_ptr[k]   = (c + 1) % N;
                        end
                    end
                end
                m_pdn[k] = (odn & ~cdn) | evt_dn;
                m_pup[k] = (oup & ~cup) | evt_up;
`ifdef BUTTON_EVT_DROP_EN
                m_drop[k] = (drop_clr ? '0 : m_drop[k]) | (evt_dn & odn) | (evt_up & oup);
`else
                m_drop[k] = '0;
`endif
            end
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- every-cycle compare ----------------
    always @(negedge CLK) begin : p_cmp
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_valid", k), (k == 0) ? bus0.out_valid : bus1.out_valid, m_valid[k]);
            chk($sformatf("d%0d_pending", k), (k == 0) ? pend0 : pend1, {m_pup[k], m_pdn[k]});
            chk($sformatf("d%0d_busy", k), (k == 0) ? busy0 : busy1, m_valid[k] || (m_hold[k] > 0));
            chk($sformatf("d%0d_drop", k), (k == 0) ? drop0 : drop1, m_drop[k]);
            if (m_valid[k]) begin
                chk($sformatf("d%0d_id", k), (k == 0) ? bus0.out_id : bus1.out_id, m_id[k]);
                chk($sformatf("d%0d_dir", k), (k == 0) ? bus0.out_dir : bus1.out_dir, m_dir[k]);
            end
        end
    end

    // ---------------- transfer monitor ----------------
    int q0[$], q1[$], hs0[$], hs1[$], rs0[$], rs1[$];
    logic pv0 = 1'b0, pv1 = 1'b0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            pv0 <= 1'b0; pv1 <= 1'b0;
        end else begin
            if (bus0.out_valid && ready) begin q0.push_back(int'({bus0.out_dir, bus0.out_id})); hs0.push_back(cyc); end
            if (bus1.out_valid && ready) begin q1.push_back(int'({bus1.out_dir, bus1.out_id})); hs1.push_back(cyc); end
            if (bus0.out_valid && !pv0) rs0.push_back(cyc);
            if (bus1.out_valid && !pv1) rs1.push_back(cyc);
            pv0 <= bus0.out_valid; pv1 <= bus1.out_valid;
        end
    end

    function automatic int ev(input int dir, input int id);
        return dir * 4 + id;
    endfunction

    task automatic tick();
        @(posedge CLK); #2;
    endtask

    task automatic clear_logs();
        q0.delete(); q1.delete(); hs0.delete(); hs1.delete(); rs0.delete(); rs1.delete();
    endtask

    task automatic do_reset();
        RST_N = 1'b0; tick(); RST_N = 1'b1; tick(); clear_logs();
    endtask

    task automatic wait_quiet(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (!busy0 && !busy1 && pend0 == '0 && pend1 == '0) ok = 1'b1;
            else tick();
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic chk_seq(input string nm, input int which, input int n, input int e0, input int e1, input int e2);
        int e[3];
        int sz;
        e[0] = e0; e[1] = e1; e[2] = e2;
        sz = (which == 0) ? q0.size() : q1.size();
        chk($sformatf("%s_d%0d_count", nm, which), sz, n);
        for (int i = 0; i < n; i++) begin
            if (i < sz) chk($sformatf("%s_d%0d_ev%0d", nm, which, i), (which == 0) ? q0[i] : q1[i], e[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inputs active
        RST_N = 1'b0; evt_dn = 4'b1111;
        repeat (3) tick();
        chk("rst_valid", bus0.out_valid, 0);
        chk("rst_pending", pend0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_id", bus1.out_id, 0);
        evt_dn = '0;
        tick();
        RST_N = 1'b1;

        // Latency: pulse ch2, offer two edges later
        repeat (4) tick();
        evt_dn = 4'b0100; tick(); evt_dn = '0;
        chk("lat_pending", pend0, 8'h04);
        chk("lat_valid_early", bus0.out_valid, 0);
        tick();
        chk("lat_valid", bus0.out_valid, 1);
        chk("lat_id", bus0.out_id, 2);
        chk("lat_dir", bus0.out_dir, 0);
        chk("lat_valid_g10", bus1.out_valid, 1);

        // Backpressure
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", bus0.out_valid, 1);
            chk("bp_id", bus1.out_id, 2);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        chk("bp_fall0", bus0.out_valid, 0);
        chk("bp_fall1", bus1.out_valid, 0);
        chk("bp_xfers", q0.size(), 1);
        wait_quiet("bp");

        // Round-robin from ptr 0, then wrapped pointer
        do_reset();
        ready = 1'b1;
        evt_dn = 4'b1011; tick(); evt_dn = '0;
        wait_quiet("rr1");
        chk_seq("rr1", 0, 3, ev(0,0), ev(0,1), ev(0,3));
        chk_seq("rr1", 1, 3, ev(0,0), ev(0,1), ev(0,3));
        chk("gap0_spacing",  (rs0.size() > 1 && hs0.size() > 0) ? rs0[1] - hs0[0] : -1, 2);
        chk("gap10_spacing", (rs1.size() > 1 && hs1.size() > 0) ? rs1[1] - hs1[0] : -1, 12);
        clear_logs();
        evt_dn = 4'b1001; tick(); evt_dn = '0;
        wait_quiet("rr2");
        chk_seq("rr2", 0, 2, ev(0,0), ev(0,3), 0);
        chk_seq("rr2", 1, 2, ev(0,0), ev(0,3), 0);

        // Same-channel press then release
        do_reset();
        ready = 1'b1;
        evt_dn = 4'b0010; evt_up = 4'b0010; tick(); evt_dn = '0; evt_up = '0;
        wait_quiet("same");
        chk_seq("same", 0, 2, ev(0,1), ev(1,1), 0);
        chk_seq("same", 1, 2, ev(0,1), ev(1,1), 0);

        // Set wins over the grant-clear
        clear_logs();
        evt_dn = 4'b0010; tick(); tick(); evt_dn = '0;
        wait_quiet("setwins");
        chk_seq("setwins", 0, 2, ev(0,1), ev(0,1), 0);
        chk_seq("setwins", 1, 2, ev(0,1), ev(0,1), 0);

        // Overflow while another event holds the offer
        do_reset();
        ready = 1'b0;
        evt_dn = 4'b1000; tick(); evt_dn = '0; tick();
        evt_dn = 4'b0001; tick(); evt_dn = '0; tick();
        evt_dn = 4'b0001; tick(); evt_dn = '0;
        chk("ovf_drop0", drop0, c_drop_exp);
        chk("ovf_drop1", drop1, c_drop_exp);
        chk("ovf_pending", pend0, 8'h01);
        ready = 1'b1;
        wait_quiet("ovf");
        chk_seq("ovf", 0, 2, ev(0,3), ev(0,0), 0);
        chk_seq("ovf", 1, 2, ev(0,3), ev(0,0), 0);
        drop_clr = 1'b1; tick(); drop_clr = 1'b0;
        chk("clr_drop0", drop0, 0);
        chk("clr_drop1", drop1, 0);

        // Overflow coinciding with clear keeps the flag
        ready = 1'b0;
        evt_dn = 4'b1000; tick(); evt_dn = '0; tick();
        evt_dn = 4'b0001; tick();
        drop_clr = 1'b1; tick(); evt_dn = '0; drop_clr = 1'b0;
        chk("ovf_clr_drop0", drop0, c_drop_exp);
        ready = 1'b1;
        wait_quiet("ovf2");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Collects debounced press (trans_dn) and release (trans_up) pulses from N debouncer channels.
- Latches each pulse as a pending event and serialises the events onto one valid/ready event stream.
- Selection is round-robin, with an enforced gap between consecutive events.
- Sits between the debouncer bank and the shared consumer (LED toggler, display or UART reporter), so one consumer serves every switch without losing simultaneous events.

Parameters:
- N, 4, number of switch channels (2..16)
- GAP_CYCLES, 1000, idle cycles after each accepted event before the next offer; 0 = no gap
- IDW, $clog2(N), width of out_id (derived, not overridden)

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST_N  in  1  reset, asynchronous assert, active-low
- evt_dn  in  N  one-cycle press pulses, bit i from debouncer i trans_dn
- evt_up  in  N  one-cycle release pulses, bit i from debouncer i trans_up
- out_valid  out  1  event offered
- out_ready  in  1  consumer accepts the event when out_valid & out_ready
- out_id  out  IDW  channel index of the offered event
- out_dir  out  1  0 = press (dn), 1 = release (up)
- pending  out  2N  {pend_up, pend_dn} status, registered
- busy  out  1  FSM not in IDLE
- drop  out  N  sticky overflow flags (see Optional Feature)
- drop_clr  in  1  clears drop

Behaviour:
- Reset (RST_N low, asynchronous): FSM=IDLE, out_valid=0, out_id=0, out_dir=0, pending=0, busy=0, drop=0, gap counter=0, round-robin pointer=0.
- Pending capture: evt_dn[i] sets pend_dn[i]; evt_up[i] sets pend_up[i] on the next edge.
  - If a set and a grant-clear hit the same bit in the same cycle, the set wins; the bit stays 1 as a new event.
- FSM IDLE:
  - If any pending bit is set, pick a channel by scanning from rr_ptr upward with wrap N-1 -> 0; first channel with any pending bit wins.
  - Within the chosen channel, dn has priority over up.
  - Register out_id/out_dir, clear the granted bit, set rr_ptr = granted+1 mod N, set out_valid=1, go to OFFER.
  - Otherwise stay in IDLE.
- FSM OFFER:
  - out_valid=1; out_id/out_dir are held stable until the handshake.
  - On out_valid & out_ready: out_valid=0 next cycle. If GAP_CYCLES==0 go to IDLE, else load counter with GAP_CYCLES-1 and go to GAP.
  - out_ready is ignored outside OFFER.
- FSM GAP: decrement each cycle; at 0 go to IDLE. Pending capture continues throughout.
- busy = (state != IDLE).
- Latency: pulse in cycle t -> pending bit visible t+1 -> out_valid high from t+2, when idle with no other pending events.
- Maximum throughput: one event per GAP_CYCLES+2 cycles when out_ready is held high.
- A press and release of the same channel both pending are reported as press, then release, in separate grants.
- Reset mid-OFFER drops the offered event and all pending events. No partial handshake survives reset.

Optional Feature:
- Macro: BUTTON_EVT_DROP_EN.
- Enabled: drop[i] is set when evt_dn[i] or evt_up[i] arrives while the matching pending bit is already 1, meaning an event was merged or lost.
  - drop is sticky; drop_clr=1 clears it on the next edge.
  - A new overflow in the same cycle as drop_clr wins over the clear.
- Disabled: drop is driven constant 0, drop_clr is unused, and no flag registers are synthesised.

Decomposition:
- Package button_evt_pkg holds:
  - the FSM state encoding: IDLE=2'd0, OFFER=2'd1, GAP=2'd2
  - localparams DIR_DN=1'b0, DIR_UP=1'b1
  - the default GAP_CYCLES
- One sub-module, rr_pick:
  - purely combinational N-bit round-robin selector
  - inputs: req[N-1:0], ptr[IDW-1:0]
  - outputs: gnt_idx[IDW-1:0], gnt_any
  - instantiated once in the arbiter.
- Counter, pending, drop registers and the FSM stay in button_event_arbiter.

Test Plan:
- Reset: hold RST_N=0 with evt_dn=4'b1111 -> all outputs 0 and pending=0. Release reset at cycle 0, pulse evt_dn[2] at cycle 5 -> out_valid=1, out_id=2, out_dir=0 at cycle 7.
- Round-robin: GAP_CYCLES=0, out_ready=1, evt_dn=4'b1011 in one cycle -> grants id 0, 1, 3 in order on consecutive handshakes. A second burst then starts the scan at channel 0 (ptr wrapped from 3).
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_id/out_dir are stable and out_valid stays 1. out_ready=1 -> exactly one transfer; out_valid falls next cycle.
- Gap timing: GAP_CYCLES=10, two pending events, out_ready=1 -> second out_valid rises exactly 12 cycles after the first handshake cycle, and busy stays high in between.
- Same-channel ordering and set-wins: evt_dn[1] and evt_up[1] together -> press then release reported. evt_dn[1] re-pulsed in the same cycle its grant clears pend_dn[1] -> a second press is reported.
- BUTTON_EVT_DROP_EN: with out_ready=0, pulse evt_dn[0] twice -> drop=4'b0001 and only one press reported. drop_clr=1 -> drop=0 next cycle. With the macro undefined -> drop stays 0.
